// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: collects a framed config command from UART bytes,
// verifies its XOR checksum, issues one SPI write and supervises chip-select
// until the transfer finishes or times out.
module spi_cfg_sequencer #(
  parameter int unsigned SPI_N_BIT    = 96,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 500_000,
  parameter int unsigned SPI_TIMEOUT  = 20_000
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [7:0]           uart_rdata,
  input  logic                 uart_vld,
  output logic                 spi_wreq,
  output logic [SPI_N_BIT-1:0] spi_wdata,
  input  logic                 spi_csn,
  output logic                 busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [1:0]           err_code,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned N_BYTES = SPI_N_BIT / 8;
  localparam int unsigned TMAX    = (BYTE_TIMEOUT > SPI_TIMEOUT) ? BYTE_TIMEOUT : SPI_TIMEOUT;
  localparam int unsigned TW      = $clog2(TMAX + 1);
  localparam int unsigned CW      = $clog2(N_BYTES + 1);

  localparam logic [TW-1:0] BYTE_LD   = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] SPI_LD    = TW'(SPI_TIMEOUT - 1);
  localparam logic [CW-1:0] N_BYTES_C = CW'(N_BYTES);

  typedef enum logic [2:0] {
    IDLE, RECV, CHECK, ISSUE, WAIT_START, WAIT_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             xor_q, xor_d;
  logic [7:0]             chk_q, chk_d;
  logic [SPI_N_BIT-1:0]   pay_q, pay_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [SPI_N_BIT-1:0]   wdata_q, wdata_d;
  logic                   wreq_q, wreq_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic [7:0]             fcnt_q, fcnt_d;

  // Next-state and registered-output decode; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    chk_d   = chk_q;
    pay_d   = pay_q;
    tmr_d   = tmr_q;
    wdata_d = wdata_q;
    wreq_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (uart_vld && uart_rdata == HEADER) begin
          state_d = RECV;
          cnt_d   = '0;
          xor_d   = '0;
          tmr_d   = BYTE_LD;
        end
      end
      RECV: begin
        if (uart_vld) begin
          tmr_d = BYTE_LD;
          if (cnt_q == N_BYTES_C) begin
            // byte after the payload is the checksum
            chk_d   = uart_rdata;
            state_d = CHECK;
          end else begin
            pay_d = {pay_q[SPI_N_BIT-9:0], uart_rdata};
            xor_d = xor_q ^ uart_rdata;
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      CHECK: begin
        if (xor_q == chk_q) begin
          wdata_d = pay_q;
          wreq_d  = 1'b1;
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        tmr_d   = SPI_LD;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!spi_csn) begin
          tmr_d   = SPI_LD;
          state_d = WAIT_DONE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (spi_csn) begin
          done_d  = 1'b1;
          code_d  = 2'd0;
          fcnt_d  = fcnt_q + 8'd1;
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // busy tracks the upcoming state so it falls with the done/err pulse
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame silently.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xor_q   <= '0;
      chk_q   <= '0;
      pay_q   <= '0;
      tmr_q   <= '0;
      wdata_q <= '0;
      wreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      chk_q   <= chk_d;
      pay_q   <= pay_d;
      tmr_q   <= tmr_d;
      wdata_q <= wdata_d;
      wreq_q  <= wreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign spi_wreq  = wreq_q;
  assign spi_wdata = wdata_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_code  = code_q;
  assign frame_cnt = fcnt_q;

endmodule
